// File: rtl/led_scan_sequencer.sv
// Running-light position sequencer for a 3-to-8 LED decoder.
// A prescaler sets the step rate; the FSM runs either wrap-around or bounce order.
module led_scan_sequencer #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_VAL = 12_500_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       mode_i,
  input  logic       dir_i,
  output logic [2:0] binary_o,
  output logic       en_o,
  output logic       busy_o,
  output logic       step_o
);

  localparam int unsigned POS_W = 3;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_VAL - 1);
  localparam logic [POS_W-1:0] POS_MIN = POS_W'(0);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(7);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               mode_q, mode_d;
  logic [POS_W-1:0]   bin_q, bin_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               tick_c;

  // Step strobe: last prescaler count while a sequence is running.
  always_comb begin
    tick_c = (state_q != IDLE) && (presc_q == DIV_MAX);
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    bin_d   = bin_q;
    en_d    = en_q;
    busy_d  = busy_q;
    step_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start_i && !stop_i) begin
          mode_d  = mode_i;
          presc_d = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          if (dir_i) begin
            state_d = RUN_DOWN;
            bin_d   = POS_MAX;
          end else begin
            state_d = RUN_UP;
            bin_d   = POS_MIN;
          end
        end
      end

      RUN_UP, RUN_DOWN: begin
        if (stop_i) begin
          // Stop wins over a coincident tick; position is frozen.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          presc_d = '0;
        end else if (tick_c) begin
          presc_d = '0;
          step_d  = 1'b1;
          if (state_q == RUN_UP) begin
            if (mode_q && (bin_q == POS_MAX)) begin
              state_d = RUN_DOWN;
              bin_d   = POS_MAX - POS_W'(1);
            end else begin
              bin_d = bin_q + POS_W'(1);
            end
          end else begin
            if (mode_q && (bin_q == POS_MIN)) begin
              state_d = RUN_UP;
              bin_d   = POS_MIN + POS_W'(1);
            end else begin
              bin_d = bin_q - POS_W'(1);
            end
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      presc_q <= '0;
      mode_q  <= 1'b0;
      bin_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
    end
  end

  assign binary_o = bin_q;
  assign en_o     = en_q;
  assign busy_o   = busy_q;
  assign step_o   = step_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Self-checking bench for led_scan_sequencer: vector table, directed sequences,
// and randomized stimulus against a step-count based reference model.
module tb_led_scan_sequencer;

  localparam int unsigned DIV_W   = 3;
  localparam int unsigned DIV_VAL = 4;

  logic       clk;
  logic       rst_ni;
  logic       start, stop, mode, dir;
  logic [2:0] binary;
  logic       en, busy, step;

  int total = 0;
  int bad   = 0;

  // Reference model: position is a function of edges elapsed since the start load.
  bit         m_run;
  int         m_n;
  bit         m_mode;
  bit         m_dir;
  logic [2:0] m_last;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [2:0] bin;
    logic       en;
    logic       step;
  } vec_t;

  vec_t tbl [20];
  logic [2:0] bexp [14];
  logic [2:0] wexp [9];

  led_scan_sequencer #(.DIV_W(DIV_W), .DIV_VAL(DIV_VAL)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .start_i (start),
    .stop_i  (stop),
    .mode_i  (mode),
    .dir_i   (dir),
    .binary_o(binary),
    .en_o    (en),
    .busy_o  (busy),
    .step_o  (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] f_pos(int n, bit md, bit dr);
    int k, t, p;
    k = n / DIV_VAL;
    if (!md) begin
      p = dr ? (15 - (k % 8)) % 8 : k % 8;
    end else begin
      t = k % 14;
      p = (t <= 7) ? t : 14 - t;
      if (dr) p = 7 - p;
    end
    return 3'(p);
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_n    = 0;
    m_last = 3'd0;
  endtask

  task automatic model_edge();
    if (!rst_ni) begin
      model_reset();
    end else if (m_run) begin
      if (stop) begin
        m_run = 1'b0;
      end else begin
        m_n    = m_n + 1;
        m_last = f_pos(m_n, m_mode, m_dir);
      end
    end else if (start && !stop) begin
      m_run  = 1'b1;
      m_n    = 0;
      m_mode = mode;
      m_dir  = dir;
      m_last = f_pos(0, mode, dir);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    logic st;
    st = m_run && (m_n > 0) && ((m_n % DIV_VAL) == 0);
    chk({tag, "_bin"},  8'(binary), 8'(m_last));
    chk({tag, "_en"},   8'(en),     8'(m_run));
    chk({tag, "_busy"}, 8'(busy),   8'(m_run));
    chk({tag, "_step"}, 8'(step),   8'(st));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin"},  8'(binary), 8'd0);
    chk({tag, "_en"},   8'(en),     8'd0);
    chk({tag, "_busy"}, 8'(busy),   8'd0);
    chk({tag, "_step"}, 8'(step),   8'd0);
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int cnt, n7, idx;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0};
    bexp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    wexp = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};

    rst_ni = 1'b1;
    start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    m_mode = 1'b0; m_dir = 1'b0;
    model_reset();

    // Asynchronous reset with no clock edge
    #2 rst_ni = 1'b0;
    #1 chk_zero("rst_async");
    repeat (2) tick_cycle();
    rst_ni = 1'b1;
    repeat (20) begin
      tick_cycle();
      chk_zero("rst_idle");
    end

    // Vector table
    for (int i = 0; i < 20; i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      mode  = tbl[i].mode;  dir  = tbl[i].dir;
      tick_cycle();
      chk($sformatf("tbl%0d_bin", i),  8'(binary), 8'(tbl[i].bin));
      chk($sformatf("tbl%0d_en", i),   8'(en),     8'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i), 8'(busy),   8'(tbl[i].en));
      chk($sformatf("tbl%0d_step", i), 8'(step),   8'(tbl[i].step));
    end
    idle_in();
    tick_cycle();

    // Wrap up: 8 steps in 32 cycles ending back at 0
    start = 1'b1; mode = 1'b0; dir = 1'b0;
    tick_cycle();
    idle_in();
    chk("wrapup_load_bin", 8'(binary), 8'd0);
    chk("wrapup_load_en",  8'(en),     8'd1);
    cnt = 0;
    repeat (32) begin
      tick_cycle();
      cmp_model("wrapup");
      if (step) cnt++;
    end
    chk("wrapup_steps", 8'(cnt), 8'd8);
    chk("wrapup_end",   8'(binary), 8'd0);
    stop = 1'b1; tick_cycle(); idle_in();
    cmp_model("wrapup_stop");

    // Wrap down with mode/dir/start wiggling mid-run
    start = 1'b1; mode = 1'b0; dir = 1'b1;
    tick_cycle();
    chk("wrapdn_load_bin", 8'(binary), 8'd7);
    idx = 0;
    repeat (36) begin
      start = 1'($urandom); mode = 1'($urandom); dir = 1'($urandom); stop = 1'b0;
      tick_cycle();
      cmp_model("wrapdn");
      if (step && idx < 9) begin
        chk($sformatf("wrapdn_seq%0d", idx), 8'(binary), 8'(wexp[idx]));
        idx++;
      end
    end
    chk("wrapdn_nsteps", 8'(idx), 8'd9);
    idle_in(); stop = 1'b1; tick_cycle(); idle_in();

    // Bounce: 14 steps per 56-cycle period, endpoint 7 held 4 cycles
    start = 1'b1; mode = 1'b1; dir = 1'b0;
    tick_cycle();
    idle_in();
    idx = 0; n7 = 0;
    repeat (56) begin
      tick_cycle();
      cmp_model("bounce");
      if (binary == 3'd7) n7++;
      if (step) begin
        if (idx < 14) chk($sformatf("bounce_seq%0d", idx), 8'(binary), 8'(bexp[idx]));
        idx++;
      end
    end
    chk("bounce_nsteps", 8'(idx), 8'd14);
    chk("bounce_top_len", 8'(n7), 8'd4);
    chk("bounce_end", 8'(binary), 8'd0);
    stop = 1'b1; tick_cycle(); idle_in();

    // Stop while showing 5
    start = 1'b1; mode = 1'b0; dir = 1'b0;
    tick_cycle();
    idle_in();
    for (int c = 0; c < 40 && !(m_run && m_last == 3'd5); c++) tick_cycle();
    chk("stop5_reached", 8'(binary), 8'd5);
    stop = 1'b1; tick_cycle(); idle_in();
    chk("stop5_en",   8'(en),     8'd0);
    chk("stop5_busy", 8'(busy),   8'd0);
    chk("stop5_bin",  8'(binary), 8'd5);
    repeat (8) begin
      tick_cycle();
      chk("stop5_nostep", 8'(step),   8'd0);
      chk("stop5_hold",   8'(binary), 8'd5);
    end
    start = 1'b1; stop = 1'b1; tick_cycle(); idle_in();
    chk("startstop_en", 8'(en), 8'd0);

    // Async reset mid-run at position 3, prescaler 2
    start = 1'b1; mode = 1'b0; dir = 1'b0;
    tick_cycle();
    idle_in();
    for (int c = 0; c < 40 && m_n != 14; c++) tick_cycle();
    chk("midrst_pos", 8'(binary), 8'd3);
    #3 rst_ni = 1'b0;
    #1 chk_zero("midrst_async");
    model_reset();
    tick_cycle();
    rst_ni = 1'b1;
    repeat (10) begin
      tick_cycle();
      chk_zero("midrst_idle");
    end

    // Randomized stimulus against the model
    repeat (600) begin
      start = ($urandom % 6) == 0;
      stop  = ($urandom % 12) == 0;
      mode  = 1'($urandom);
      dir   = 1'($urandom);
      tick_cycle();
      cmp_model("rnd");
      if (($urandom % 150) == 0) begin
        #3 rst_ni = 1'b0;
        #1 chk_zero("rnd_rst");
        model_reset();
        idle_in();
        tick_cycle();
        rst_ni = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
